// File: rtl/cfg_pkg.sv
// Shared types and constants for the display configuration write path.
package cfg_pkg;

  localparam int NUM_REGISTERS = 7;
  localparam int LEN_REGISTER  = 8;
  localparam int ADDR_W        = $clog2(NUM_REGISTERS);

  // Register map of the display configuration bank.
  typedef enum logic [ADDR_W-1:0] {
    REG_COLOR1   = 3'd0,
    REG_COLOR2   = 3'd1,
    REG_COLOR3   = 3'd2,
    REG_COLOR4   = 3'd3,
    REG_SPRITE_X = 3'd4,
    REG_SPRITE_Y = 3'd5,
    REG_MISC     = 3'd6
  } reg_idx_e;

  // One pending register write.
  typedef struct packed {
    logic [ADDR_W-1:0]       addr;
    logic [LEN_REGISTER-1:0] data;
  } cfg_write_t;

  // Arbiter priority state.
  typedef enum logic {
    SPI_PRI  = 1'b0,
    AUTO_PRI = 1'b1
  } arb_state_e;

  // True when the address maps onto an implemented register.
  function automatic logic addr_valid(input logic [ADDR_W-1:0] addr);
    return int'(addr) < NUM_REGISTERS;
  endfunction

endpackage

// File: rtl/cfg_fifo.sv
// Synchronous FIFO of pending configuration writes. A push while full is
// accepted when a pop happens in the same cycle.
module cfg_fifo
  import cfg_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  cfg_write_t               push_data_i,
  input  logic                     pop_i,
  output cfg_write_t               head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  cfg_write_t         r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [LVL_W-1:0]   r_level;

  logic w_do_pop;
  logic w_do_push;

  assign empty_o   = (r_level == '0);
  assign full_o    = (r_level == LVL_W'(DEPTH));
  assign w_do_pop  = pop_i && !empty_o;
  assign w_do_push = push_i && (!full_o || w_do_pop);
  assign head_o    = r_mem[r_rd_ptr];
  assign level_o   = r_level;

  // Storage array: written on accepted push only.
  // NOTE: the data array has no reset; validity is tracked by the pointers
  // and level, so clearing the entries would only cost reset fan-out.
  always_ff @(posedge clk_i) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data_i;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/cfg_write_scheduler.sv
// Merges SPI-command writes (buffered) and sprite-engine writes into a single
// registered write port, optionally gated to the vertical blanking window.
module cfg_write_scheduler
  import cfg_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int SPI_BURST  = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          spi_wr_valid_i,
  input  logic [ADDR_W-1:0]             spi_wr_addr_i,
  input  logic [LEN_REGISTER-1:0]       spi_wr_data_i,
  input  logic                          auto_req_i,
  input  logic [ADDR_W-1:0]             auto_addr_i,
  input  logic [LEN_REGISTER-1:0]       auto_data_i,
  output logic                          auto_gnt_o,
  input  logic                          sync_mode_i,
  input  logic                          vblank_i,
  output logic                          reg_we_o,
  output logic [ADDR_W-1:0]             reg_addr_o,
  output logic [LEN_REGISTER-1:0]       reg_data_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          overflow_o,
  output logic                          bad_addr_o
);

  localparam int                CNT_W      = $clog2(SPI_BURST + 1);
  localparam logic [CNT_W-1:0]  BURST_LAST = CNT_W'(SPI_BURST);

  arb_state_e               r_state;
  logic [CNT_W-1:0]         r_burst_cnt;
  logic                     r_reg_we;
  logic [ADDR_W-1:0]        r_reg_addr;
  logic [LEN_REGISTER-1:0]  r_reg_data;
  logic                     r_auto_gnt;
  logic                     r_overflow;
  logic                     r_bad_addr;

  cfg_write_t               w_head;
  logic                     w_fifo_full;
  logic                     w_fifo_empty;
  logic                     w_spi_addr_ok;
  logic                     w_auto_addr_ok;
  logic                     w_push;
  logic                     w_issue_ok;
  logic                     w_auto_elig;
  logic                     w_sel_spi;
  logic                     w_sel_auto;
  logic [CNT_W-1:0]         w_cnt_inc;

  assign w_spi_addr_ok  = addr_valid(spi_wr_addr_i);
  assign w_auto_addr_ok = addr_valid(auto_addr_i);
  assign w_push         = spi_wr_valid_i && w_spi_addr_ok;
  assign w_issue_ok     = !sync_mode_i || vblank_i;
  // The cycle after a grant the requester has not yet dropped req; skip it.
  assign w_auto_elig    = auto_req_i && !r_auto_gnt;
  assign w_cnt_inc      = r_burst_cnt + 1'b1;

  cfg_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (w_push),
    .push_data_i ('{addr: spi_wr_addr_i, data: spi_wr_data_i}),
    .pop_i       (w_sel_spi),
    .head_o      (w_head),
    .full_o      (w_fifo_full),
    .empty_o     (w_fifo_empty),
    .level_o     (fifo_level_o)
  );

  // Source selection for this cycle; the FIFO head is popped when chosen.
  // NOTE: both selects get a default first so no path through the block
  // leaves them unassigned, which would otherwise infer latches.
  always_comb begin
    w_sel_spi  = 1'b0;
    w_sel_auto = 1'b0;
    if (w_issue_ok) begin
      if (r_state == AUTO_PRI && w_auto_elig) w_sel_auto = 1'b1;
      else if (!w_fifo_empty)                 w_sel_spi  = 1'b1;
      else if (w_auto_elig)                   w_sel_auto = 1'b1;
    end
  end

  // Arbiter FSM with burst counter and the registered write port / grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= SPI_PRI;
      r_burst_cnt <= '0;
      r_reg_we    <= 1'b0;
      r_reg_addr  <= '0;
      r_reg_data  <= '0;
      r_auto_gnt  <= 1'b0;
    end else begin
      r_auto_gnt <= w_sel_auto;
      r_reg_we   <= w_sel_spi || (w_sel_auto && w_auto_addr_ok);
      if (w_sel_spi) begin
        r_reg_addr <= w_head.addr;
        r_reg_data <= w_head.data;
      end else if (w_sel_auto && w_auto_addr_ok) begin
        r_reg_addr <= auto_addr_i;
        r_reg_data <= auto_data_i;
      end

      case (r_state)
        SPI_PRI: begin
          if (!auto_req_i) begin
            r_burst_cnt <= '0;
          end else if (w_sel_spi) begin
            r_burst_cnt <= w_cnt_inc;
            if (w_cnt_inc == BURST_LAST) r_state <= AUTO_PRI;
          end else if (w_sel_auto) begin
            r_burst_cnt <= '0;
          end
        end
        AUTO_PRI: begin
          if (w_sel_auto) begin
            r_state     <= SPI_PRI;
            r_burst_cnt <= '0;
          end else if (!auto_req_i) begin
            r_burst_cnt <= '0;
          end
        end
        default: begin
          r_state     <= SPI_PRI;
          r_burst_cnt <= '0;
        end
      endcase
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_overflow <= 1'b0;
      r_bad_addr <= 1'b0;
    end else begin
      if (w_push && w_fifo_full && !w_sel_spi) r_overflow <= 1'b1;
      if ((spi_wr_valid_i && !w_spi_addr_ok) || (auto_req_i && !w_auto_addr_ok))
        r_bad_addr <= 1'b1;
    end
  end

  assign reg_we_o   = r_reg_we;
  assign reg_addr_o = r_reg_addr;
  assign reg_data_o = r_reg_data;
  assign auto_gnt_o = r_auto_gnt;
  assign overflow_o = r_overflow;
  assign bad_addr_o = r_bad_addr;

endmodule
